// File: rtl/intc_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | intc_if : peripheral-bus and CPU interrupt handshake for intc        |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface intc_if #(
  parameter int NSRC = 8
);
  logic [1:0]      AD;
  logic [7:0]      DI;
  logic [7:0]      DO;
  logic            rw;
  logic            cs;
  logic [NSRC-1:0] src;
  logic            iack;
  logic            irq;
  logic [2:0]      ivec;

  modport master (output AD, DI, rw, cs, src, iack, input DO, irq, ivec);
  modport slave  (input AD, DI, rw, cs, src, iack, output DO, irq, ivec);
endinterface
`default_nettype wire

// File: rtl/intc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | intc : eight-input latching/masking/prioritising interrupt controller|
// | Optional nested priority when INTC_NEST_EN is defined.               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module intc #(
  parameter int NSRC = 8
) (
  input  logic  clk,
  input  logic  rst,
  intc_if.slave bus
);
  logic [NSRC-1:0] s1, s2, epend, imr, elr, isr;
  logic            req;
  logic [2:0]      ack_vec;

  logic [NSRC-1:0] ipr, cand, best_oh, e_set, e_clr, elr_n, epend_n, isr_n;
  logic [2:0]      best;
  logic            wr, eoi, ack, elig, irq_n;
  logic [7:0]      rd;

  assign wr  = bus.cs & ~bus.rw;
  assign eoi = wr & (bus.AD == 2'd3);
  assign ack = bus.iack & req;

  always_comb begin
    ipr  = (epend & elr) | (s1 & ~elr);
    cand = ipr & imr;
    best = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) best = 3'(i);
    end
    for (int i = 0; i < NSRC; i++) begin
      best_oh[i] = (best == 3'(i));
    end
  end

  // Edge sets win over clears; retyping a bit's trigger mode drops its latched edge.
  always_comb begin
    e_set = s1 & ~s2 & elr;
    e_clr = ack ? best_oh : '0;
    if (wr && bus.AD == 2'd0) e_clr = e_clr | bus.DI[NSRC-1:0];
    elr_n   = (wr && bus.AD == 2'd2) ? bus.DI[NSRC-1:0] : elr;
    epend_n = (e_set | (epend & ~e_clr)) & ~(elr ^ elr_n);
    isr_n   = eoi ? (isr & (isr - NSRC'(1))) : isr;
    if (ack) isr_n = isr_n | best_oh;
  end

`ifdef INTC_NEST_EN
  logic [2:0] isr_low;

  always_comb begin
    isr_low = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (isr[i]) isr_low = 3'(i);
    end
  end

  assign elig = (|cand) && ((isr == '0) || (best < isr_low));
`else
  assign elig = (|cand) && (isr == '0);
`endif

  assign irq_n = elig & ~ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      epend   <= '0;
      imr     <= '0;
      elr     <= '0;
      isr     <= '0;
      req     <= 1'b0;
      ack_vec <= '0;
    end else begin
      s1    <= bus.src;
      s2    <= s1;
      epend <= epend_n;
      elr   <= elr_n;
      isr   <= isr_n;
      req   <= irq_n;
      if (wr && bus.AD == 2'd1) imr <= bus.DI[NSRC-1:0];
      if (ack) ack_vec <= best;
    end
  end

  always_comb begin
    rd = '0;
    case (bus.AD)
      2'd0:    rd[NSRC-1:0] = ipr;
      2'd1:    rd[NSRC-1:0] = imr;
      2'd2:    rd[NSRC-1:0] = elr;
      default: rd = {req, |isr, 3'b000, best};
    endcase
  end

  assign bus.DO   = rd;
  assign bus.irq  = req;
  assign bus.ivec = ack_vec;
endmodule
`default_nettype wire
